// File: rtl/sodor5_itype_pkg.sv
// -----------------------------------------------------------------------------
// sodor5_itype_pkg
// Shared definitions for the Sodor 5-stage I-type trace checkers:
//   OPC_OP_IMM     - major opcode of the OP-IMM instruction group
//   funct3_e       - funct3 encodings of the OP-IMM group
//   alu_op_e       - decoded ALU operation (OP_ILLEGAL for any decode failure)
//   retire_rec_t   - one in-order retire record
//   decode_op()    - opcode/funct3/funct7 -> alu_op_e
// -----------------------------------------------------------------------------
package sodor5_itype_pkg;

    localparam int         XLEN       = 32;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        F3_ADDI  = 3'd0,
        F3_SLLI  = 3'd1,
        F3_SLTI  = 3'd2,
        F3_SLTIU = 3'd3,
        F3_XORI  = 3'd4,
        F3_SRXI  = 3'd5,   // SRLI / SRAI, selected by imm[11:5]
        F3_ORI   = 3'd6,
        F3_ANDI  = 3'd7
    } funct3_e;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_OR,
        OP_AND,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_ILLEGAL
    } alu_op_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            we;
        logic            illegal;
    } retire_rec_t;

    // funct7 is imm[11:5]; it only qualifies the shift encodings.
    function automatic alu_op_e decode_op(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7);
        alu_op_e op;
        op = OP_ILLEGAL;
        if (opcode == OPC_OP_IMM) begin
            case (funct3_e'(funct3))
                F3_ADDI:  op = OP_ADD;
                F3_SLTI:  op = OP_SLT;
                F3_SLTIU: op = OP_SLTU;
                F3_XORI:  op = OP_XOR;
                F3_ORI:   op = OP_OR;
                F3_ANDI:  op = OP_AND;
                F3_SLLI:  if (funct7 == 7'h00) op = OP_SLL;
                F3_SRXI: begin
                    if (funct7 == 7'h00)      op = OP_SRL;
                    else if (funct7 == 7'h20) op = OP_SRA;
                end
                default:  op = OP_ILLEGAL;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/itype_alu.sv
// -----------------------------------------------------------------------------
// itype_alu
// Combinational OP-IMM execute unit shared by the I-type trace checkers.
//   op       in  alu_op_e  decoded operation
//   operand  in  W         rs1 value
//   imm      in  12        raw immediate (sign-extended here; shamt = imm[4:0])
//   result   out W         computed value, 0 for an illegal op
//   illegal  out 1         decode failure
// -----------------------------------------------------------------------------
module itype_alu
    import sodor5_itype_pkg::*;
#(
    parameter int W = 32
) (
    input  alu_op_e      op,
    input  logic [W-1:0] operand,
    input  logic [11:0]  imm,
    output logic [W-1:0] result,
    output logic         illegal
);

    logic [W-1:0] imm_sx;
    logic [4:0]   shamt;

    assign imm_sx = {{(W-12){imm[11]}}, imm};
    assign shamt  = imm[4:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = operand + imm_sx;
            OP_SLT:  result = {{(W-1){1'b0}}, $signed(operand) < $signed(imm_sx)};
            OP_SLTU: result = {{(W-1){1'b0}}, operand < imm_sx};
            OP_XOR:  result = operand ^ imm_sx;
            OP_OR:   result = operand | imm_sx;
            OP_AND:  result = operand & imm_sx;
            OP_SLL:  result = operand << shamt;
            OP_SRL:  result = operand >> shamt;
            OP_SRA:  result = $unsigned($signed(operand) >>> shamt);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/itype_ref_exec.sv
// -----------------------------------------------------------------------------
// itype_ref_exec
// Reference executor for OP-IMM instruction traces. Two stages: S1 holds the
// decoded instruction and its rs1 operand, S2 holds the retire record. A
// private shadow register file is preloaded while idle and updated as
// instructions leave S1.
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_instr          instruction input handshake
//   load_en/load_addr/load_data         shadow regfile preload (idle only)
//   busy                                any stage occupied
//   ret_valid/ret_ready                 retire handshake
//   ret_instr/rd/wdata/we/illegal/seq   retire record
// -----------------------------------------------------------------------------
module itype_ref_exec
    import sodor5_itype_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int WORD_SIZE = 32,
    parameter int SEQ_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic                 load_en,
    input  logic [4:0]           load_addr,
    input  logic [WORD_SIZE-1:0] load_data,
    output logic                 busy,
    output logic                 ret_valid,
    input  logic                 ret_ready,
    output logic [31:0]          ret_instr,
    output logic [4:0]           ret_rd,
    output logic [WORD_SIZE-1:0] ret_wdata,
    output logic                 ret_we,
    output logic                 ret_illegal,
    output logic [SEQ_W-1:0]     ret_seq
);

    // S1: decoded instruction
    logic                 s1_valid;
    logic [31:0]          s1_instr;
    alu_op_e              s1_op;
    logic [WORD_SIZE-1:0] s1_opa;

    // S2: retire record
    logic                 s2_valid;
    retire_rec_t          s2_rec;
    logic [SEQ_W-1:0]     seq;

    logic [WORD_SIZE-1:0] regs [NUM_REGS];

    logic [WORD_SIZE-1:0] alu_result;
    logic                 alu_illegal;
    logic [4:0]           s1_rd;
    logic                 s1_we;
    logic                 s2_take;
    logic                 s1_adv;
    logic                 in_fire;
    logic                 wb_en;
    logic                 load_ok;
    logic [4:0]           rs1;
    logic [WORD_SIZE-1:0] rf_rs1;
    logic [WORD_SIZE-1:0] opa_in;

    itype_alu #(.W(WORD_SIZE)) u_alu (
        .op      (s1_op),
        .operand (s1_opa),
        .imm     (s1_instr[31:20]),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    assign s1_rd   = s1_instr[11:7];
    assign s1_we   = !alu_illegal && (s1_rd != 5'd0);
    assign s2_take = !s2_valid || ret_ready;
    assign s1_adv  = s1_valid && s2_take;
    assign wb_en   = s1_adv && s1_we;

    // Gated by reset so the input is refused while the pipeline is held clear.
    assign in_ready = reset && !load_en && (!s1_valid || s1_adv);
    assign in_fire  = in_valid && in_ready;

    assign busy    = s1_valid || s2_valid;
    assign load_ok = load_en && !busy && (load_addr != 5'd0);

    // The instruction leaving S1 this cycle writes the regfile at the same
    // edge the new one samples its operand, so forward its result directly.
    assign rs1    = in_instr[19:15];
    assign rf_rs1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign opa_in = (wb_en && (s1_rd == rs1)) ? alu_result : rf_rs1;

    // NOTE: the shadow regfile has no reset branch; its contents survive reset and are set by preload.
    always_ff @(posedge clk) begin
        if (wb_en)
            regs[s1_rd] <= alu_result;
        else if (load_ok)
            regs[load_addr] <= load_data;
    end

    // NOTE: all sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_op    <= OP_ILLEGAL;
            s1_opa   <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_instr <= in_instr;
            s1_op    <= decode_op(in_instr[6:0], in_instr[14:12], in_instr[31:25]);
            s1_opa   <= opa_in;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_rec   <= '0;
        end else if (s2_take) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_rec.instr   <= s1_instr;
                s2_rec.rd      <= s1_rd;
                s2_rec.wdata   <= alu_result;
                s2_rec.we      <= s1_we;
                s2_rec.illegal <= alu_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            seq <= '0;
        else if (s2_valid && ret_ready)
            seq <= seq + 1'b1;
    end

    assign ret_valid   = s2_valid;
    assign ret_instr   = s2_rec.instr;
    assign ret_rd      = s2_rec.rd;
    assign ret_wdata   = s2_rec.wdata;
    assign ret_we      = s2_rec.we;
    assign ret_illegal = s2_rec.illegal;
    assign ret_seq     = seq;

endmodule

// File: tb/tb_itype_ref_exec.sv
// -----------------------------------------------------------------------------
// tb_itype_ref_exec
// Directed and randomized stimulus for itype_ref_exec. Expected retire records
// come from an instruction-level model: a register array updated in program
// order and a queue of records still inside the pipeline.
// -----------------------------------------------------------------------------
module tb_itype_ref_exec;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        we;
        logic        illegal;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        busy;
    logic        ret_valid;
    logic        ret_ready;
    logic [31:0] ret_instr;
    logic [4:0]  ret_rd;
    logic [31:0] ret_wdata;
    logic        ret_we;
    logic        ret_illegal;
    logic [15:0] ret_seq;

    logic [31:0] mregs [32];
    rec_t        exp_q [$];
    logic [15:0] mseq;
    int          checks;
    int          errors;
    bit          fired;

    itype_ref_exec dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .busy        (busy),
        .ret_valid   (ret_valid),
        .ret_ready   (ret_ready),
        .ret_instr   (ret_instr),
        .ret_rd      (ret_rd),
        .ret_wdata   (ret_wdata),
        .ret_we      (ret_we),
        .ret_illegal (ret_illegal),
        .ret_seq     (ret_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    // Instruction semantics straight from the ISA rules.
    function automatic rec_t ref_exec(input logic [31:0] instr, input logic [31:0] a);
        rec_t        r;
        logic [31:0] sx;
        logic [4:0]  sh;
        logic [6:0]  hi;
        logic        ok;
        sx      = {{20{instr[31]}}, instr[31:20]};
        sh      = instr[24:20];
        hi      = instr[31:25];
        r.instr = instr;
        r.rd    = instr[11:7];
        r.wdata = 32'd0;
        ok      = (instr[6:0] == 7'h13);
        if (ok) begin
            case (instr[14:12])
                3'd0: r.wdata = a + sx;
                3'd1: if (hi == 7'h00) r.wdata = a << sh; else ok = 1'b0;
                3'd2: r.wdata = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
                3'd3: r.wdata = (a < sx) ? 32'd1 : 32'd0;
                3'd4: r.wdata = a ^ sx;
                3'd5: begin
                    if (hi == 7'h00)      r.wdata = a >> sh;
                    else if (hi == 7'h20) r.wdata = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                    else                  ok = 1'b0;
                end
                3'd6: r.wdata = a | sx;
                default: r.wdata = a & sx;
            endcase
        end
        if (!ok) r.wdata = 32'd0;
        r.illegal = !ok;
        r.we      = ok && (r.rd != 5'd0);
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          pick;
        f3   = 3'($urandom);
        imm  = 12'($urandom);
        pick = int'($urandom_range(0, 3));
        if (f3 == 3'd1 || f3 == 3'd5) begin
            if (pick == 0 || pick == 2) imm[11:5] = 7'h00;
            else if (pick == 1)         imm[11:5] = 7'h20;
        end
        w = enc(f3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm);
        if ($urandom_range(0, 15) == 0) w[6:0] = 7'($urandom);
        return w;
    endfunction

    // Called at the falling edge: observe what the next rising edge will do.
    task automatic sample();
        rec_t        r;
        logic [31:0] a;
        fired = in_valid && in_ready;
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
        if (load_en && exp_q.size() == 0 && load_addr != 5'd0)
            mregs[load_addr] = load_data;
        if (ret_valid) begin
            check("ret_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("ret_instr",   ret_instr,          exp_q[0].instr);
                check("ret_rd",      32'(ret_rd),        32'(exp_q[0].rd));
                check("ret_wdata",   ret_wdata,          exp_q[0].wdata);
                check("ret_we",      32'(ret_we),        32'(exp_q[0].we));
                check("ret_illegal", 32'(ret_illegal),   32'(exp_q[0].illegal));
                check("ret_seq",     32'(ret_seq),       32'(mseq));
                if (ret_ready) begin
                    void'(exp_q.pop_front());
                    mseq++;
                end
            end
        end
        if (fired) begin
            a = (in_instr[19:15] == 5'd0) ? 32'd0 : mregs[in_instr[19:15]];
            r = ref_exec(in_instr, a);
            exp_q.push_back(r);
            if (r.we) mregs[r.rd] = r.wdata;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = instr;
        fired    = 1'b0;
        while (!fired && n < 50) begin
            step();
            n++;
        end
        check("send_accepted", 32'(fired), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [4:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        step();
        load_en   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        ret_ready = 1'b1;
        in_valid  = 1'b0;
        load_en   = 1'b0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Leaves the single instruction's record on the retire port for inspection.
    task automatic exec1(input logic [31:0] instr);
        ret_ready = 1'b1;
        send(instr);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_ret_valid", 32'(ret_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_seq",       32'(ret_seq),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        exp_q.delete();
        mseq = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] bp [4];
        int          idx;
        int          acc;
        int          n;

        checks    = 0;
        errors    = 0;
        mseq      = '0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        load_en   = 1'b0;
        load_addr = 5'd0;
        load_data = 32'd0;
        ret_ready = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

        // Reset state
        #1;
        check("init_in_ready",    32'(in_ready),    32'd0);
        check("init_ret_valid",   32'(ret_valid),   32'd0);
        check("init_busy",        32'(busy),        32'd0);
        check("init_seq",         32'(ret_seq),     32'd0);
        check("init_ret_instr",   ret_instr,        32'd0);
        check("init_ret_rd",      32'(ret_rd),      32'd0);
        check("init_ret_wdata",   ret_wdata,        32'd0);
        check("init_ret_we",      32'(ret_we),      32'd0);
        check("init_ret_illegal", 32'(ret_illegal), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("first_in_ready", 32'(in_ready), 32'd1);

        for (int i = 1; i < 32; i++) load(5'(i), $urandom);

        // Preload then ADDI x6,x5,-1 with latency 2
        load(5'd5, 32'h0000_0010);
        ret_ready = 1'b1;
        send(32'hFFF2_8313);
        check("lat_t1_valid", 32'(ret_valid), 32'd0);
        step();
        check("lat_t2_valid", 32'(ret_valid), 32'd1);
        check("addi_seq",     32'(ret_seq),   32'd0);
        check("addi_rd",      32'(ret_rd),    32'd6);
        check("addi_wdata",   ret_wdata,      32'h0000_000F);
        check("addi_we",      32'(ret_we),    32'd1);
        drain();

        // Back-to-back dependent ADDIs through the bypass
        in_valid = 1'b1;
        in_instr = enc(3'd0, 5'd1, 5'd0, 12'd5);
        step();
        check("b2b_acc0", 32'(fired), 32'd1);
        in_instr = enc(3'd0, 5'd1, 5'd1, 12'd5);
        step();
        check("b2b_acc1", 32'(fired), 32'd1);
        in_valid = 1'b0;
        check("b2b_wdata0", ret_wdata, 32'd5);
        step();
        check("b2b_wdata1", ret_wdata, 32'd10);
        drain();

        // Shifts
        load(5'd3, 32'h8000_0000);
        exec1(enc(3'd5, 5'd2, 5'd3, {7'h20, 5'd4}));
        check("srai_wdata", ret_wdata, 32'hF800_0000);
        drain();
        exec1(enc(3'd5, 5'd2, 5'd3, 12'd4));
        check("srli_wdata", ret_wdata, 32'h0800_0000);
        drain();
        exec1(enc(3'd1, 5'd2, 5'd3, {7'h01, 5'd4}));
        check("slli_bad_illegal", 32'(ret_illegal), 32'd1);
        check("slli_bad_we",      32'(ret_we),      32'd0);
        check("slli_bad_wdata",   ret_wdata,        32'd0);
        drain();

        // Compares and x0 destination
        exec1(enc(3'd3, 5'd4, 5'd0, 12'hFFF));
        check("sltiu_wdata", ret_wdata, 32'd1);
        drain();
        exec1(enc(3'd2, 5'd4, 5'd0, 12'hFFF));
        check("slti_wdata", ret_wdata, 32'd0);
        drain();
        exec1(32'h0000_0013);
        check("nop_we", 32'(ret_we), 32'd0);
        drain();

        // Load to x0 ignored; load while busy ignored
        load(5'd0, 32'hDEAD_BEEF);
        exec1(enc(3'd0, 5'd11, 5'd0, 12'd0));
        check("x0_read", ret_wdata, 32'd0);
        drain();
        ret_ready = 1'b0;
        send(enc(3'd0, 5'd15, 5'd0, 12'd7));
        load(5'd15, 32'h0000_FFFF);
        drain();
        exec1(enc(3'd0, 5'd16, 5'd15, 12'd0));
        check("busy_load_ignored", ret_wdata, 32'd7);
        drain();

        // Back-pressure: 4 instructions, ret_ready low for 5 cycles
        do_reset();
        bp[0] = enc(3'd0, 5'd12, 5'd0,  12'd1);
        bp[1] = enc(3'd0, 5'd12, 5'd12, 12'd1);
        bp[2] = enc(3'd0, 5'd13, 5'd12, 12'd3);
        bp[3] = enc(3'd4, 5'd14, 5'd13, 12'h0F0);
        ret_ready = 1'b0;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            in_instr = bp[idx % 4];
            step();
            if (fired) begin
                idx++;
                acc++;
            end
        end
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        ret_ready = 1'b1;
        n = 0;
        while (idx < 4 && n < 50) begin
            in_valid = 1'b1;
            in_instr = bp[idx];
            step();
            if (fired) idx++;
            n++;
        end
        in_valid = 1'b0;
        drain();
        check("bp_retired", 32'(mseq), 32'd4);

        // Reset with two instructions in flight
        ret_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = enc(3'd0, 5'd8, 5'd0, 12'h123);
        step();
        in_instr  = enc(3'd0, 5'd9, 5'd0, 12'h456);
        step();
        in_valid  = 1'b0;
        check("inflight_busy", 32'(busy), 32'd1);
        do_reset();
        load(5'd9, 32'h0BAD_F00D);
        exec1(enc(3'd0, 5'd10, 5'd8, 12'd0));
        check("post_rst_seq",   32'(ret_seq), 32'd0);
        check("post_rst_wdata", ret_wdata,    32'h0000_0123);
        drain();

        // Randomized traffic with back-pressure and stray preloads
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            ret_ready = ($urandom_range(0, 3) != 0);
            load_en   = ($urandom_range(0, 9) == 0);
            load_addr = 5'($urandom_range(0, 7));
            load_data = $urandom;
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/itype_ref_exec.md
# itype_ref_exec

Decoder-side reference executor for the Sodor 5-stage I-type instruction traces. It consumes the 32-bit OP-IMM instruction words that the trace stimulus encodes into the imem response stream, decodes and executes them against a private 32×32 shadow register file, and emits one in-order retire record per instruction. Verification benches compare these records against the core's writeback.

## Interface
- `NUM_REGS`, 32: shadow register count; fixed at 32 for RV32I.
- `WORD_SIZE`, 32: datapath width.
- `SEQ_W`, 16: width of the retire sequence counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserted when `reset` is 0.
- `in_valid` in 1: instruction word offered.
- `in_ready` out 1: instruction accepted when `in_valid` and `in_ready` are both high.
- `in_instr` in 32: encoded as {imm[11:0], rs1, funct3, rd, opcode}.
- `load_en` in 1: shadow regfile preload strobe. Legal only while `busy` is 0.
- `load_addr` in 5: preload index.
- `load_data` in 32: preload value.
- `busy` out 1: high when any pipeline stage holds a valid entry.
- `ret_valid` out 1: retire record valid.
- `ret_ready` in 1: record consumed when `ret_valid` and `ret_ready` are both high.
- `ret_instr` out 32: retired instruction word.
- `ret_rd` out 5: destination register.
- `ret_wdata` out 32: computed result. Forced to 0 when the instruction is illegal.
- `ret_we` out 1: regfile written. Equal to (legal && rd!=0).
- `ret_illegal` out 1: decode failure.
- `ret_seq` out SEQ_W: retire index, starting at 0.

## Operation
- Stage S1 (decode) holds the decoded fields and the rs1 operand.
- Stage S2 (retire) holds the output record.
- Handshakes:
  - S2 accepts from S1 when S2 is empty or `ret_ready` is high.
  - `in_ready` = !load_en && (S1 empty or S1 advancing).
- Regfile:
  - Written by the S1→S2 transfer when `ret_we` would be set.
  - Written by `load_en`.
  - Reads of x0 return 0. Loads to x0 are ignored.
- Operand bypass: on input acceptance, rs1 is read from the regfile. If S1 is advancing in the same cycle with write enable and S1.rd == rs1, the S1 ALU result is forwarded instead.
- Decode (imm sign-extended 12→32; shamt = imm[4:0]):
  - funct3 0: ADDI.
  - funct3 2: SLTI, signed compare; result 1/0.
  - funct3 3: SLTIU, unsigned compare against the sign-extended imm.
  - funct3 4: XORI.
  - funct3 6: ORI.
  - funct3 7: ANDI.
  - funct3 1: SLLI; legal only if imm[11:5] = 0.
  - funct3 5: SRLI if imm[11:5] = 0, SRAI if imm[11:5] = 0x20; any other value is illegal.
- Any opcode other than 7'b0010011 is illegal.
- Illegal instructions still retire: `ret_illegal`=1, `ret_we`=0, no regfile write.
- All arithmetic is modulo 2^32; ADDI overflow wraps.
- `ret_seq` increments per retire handshake and wraps at 2^SEQ_W−1 → 0.
- `load_en` while `busy`=1 is ignored (no write).

## Timing
- Reset values:
  - `in_ready`=0 during reset, 1 in the first cycle after release.
  - `ret_valid`=0, `busy`=0, `ret_seq` counter=0.
  - All `ret_*` data outputs = 0.
  - Shadow regfile is not reset; it is initialised via preload.
- Latency: input accepted at edge t → `ret_valid` high after edge t+1, with the result visible in the same cycle.
- Throughput is one instruction per cycle while `ret_ready`=1.
- Back-pressure:
  - With `ret_ready`=0, S2 holds and S1 fills.
  - `in_ready` drops one cycle after S1 becomes valid behind a stalled S2.
  - No record is ever dropped or duplicated.
- A regfile write becomes architecturally visible to the instruction accepted in the same cycle through the bypass path, and to later instructions from the regfile itself.
- Reset asserted mid-stream:
  - Both stages are invalidated immediately and the counter is cleared.
  - Shadow regfile contents are retained.

## Structure
- Package `sodor5_itype_pkg`:
  - `OPC_OP_IMM`.
  - funct3 enum (`F3_ADDI`…`F3_ANDI`).
  - Decoded-op typedef.
  - Retire-record struct.
- Sub-module `itype_alu`: combinational op/operand/imm → result and illegal flag; shared with other trace checkers.

## Test plan
- Preload x5=0x00000010, then issue ADDI x6,x5,-1 (0xFFF28313) → seq 0, rd=6, wdata=0x0000000F, we=1, at latency 2.
- Back-to-back ADDI x1,x0,5 then ADDI x1,x1,5 with `ret_ready`=1 → wdata 5 then 10 (bypass path).
- SRAI x2,x3,4 with x3=0x80000000 → wdata 0xF8000000. SRLI on the same operand → 0x08000000. SLLI with imm[11:5]=0x01 → illegal=1, we=0.
- SLTIU x4,x0,-1 → wdata 1. SLTI x4,x0,-1 → wdata 0. ADDI x0,x0,0 → we=0.
- Hold `ret_ready`=0 for 5 cycles while feeding 4 instructions → `in_ready` low after 2 accepted; all 4 retire in order with seq 0..3 once released.
- Assert reset for 1 cycle with 2 instructions in flight → `ret_valid`=0 immediately; the next retire carries seq 0, and regfile values written before reset persist.
